// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one self-timed 4-phase adder among N clocked requesters.
// Optional watchdog enabled by defining ADDER_ARB_TIMEOUT_EN.
module adder_arbiter #(
    parameter int WIDTH   = 10,
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_op1,
    input  logic [N*WIDTH-1:0] req_op2,
    output logic [N-1:0]       req_ready,
    output logic [N-1:0]       resp_valid,
    output logic [WIDTH-1:0]   resp_data,
    input  logic [N-1:0]       resp_ready,
    output logic               add_lreq1,
    output logic               add_lreq2,
    output logic [WIDTH-1:0]   add_ldata1,
    output logic [WIDTH-1:0]   add_ldata2,
    input  logic               add_lack1,
    input  logic               add_lack2,
    input  logic               add_rreq,
    input  logic [WIDTH-1:0]   add_rdata,
    output logic               add_rack,
    output logic               timeout_err
);

    localparam int PW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE    = 3'd1;
    localparam logic [2:0] IN_RTZ   = 3'd2;
    localparam logic [2:0] OUT_WAIT = 3'd3;
    localparam logic [2:0] OUT_RTZ  = 3'd4;
    localparam logic [2:0] RESP     = 3'd5;

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
        $error("adder_arbiter: parameter out of range");
    end

    logic [2:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cur;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    logic          moving;
    logic          tmo;
    logic [1:0]    lack1_sy;
    logic [1:0]    lack2_sy;
    logic [1:0]    rreq_sy;
    logic          lack1_s;
    logic          lack2_s;
    logic          rreq_s;

    assign lack1_s = lack1_sy[1];
    assign lack2_s = lack2_sy[1];
    assign rreq_s  = rreq_sy[1];
    assign nxt_ptr = (cur == PW'(N - 1)) ? '0 : cur + 1'b1;

    // The adder handshake signals are asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lack1_sy <= '0;
            lack2_sy <= '0;
            rreq_sy  <= '0;
        end else begin
            lack1_sy <= {lack1_sy[0], add_lack1};
            lack2_sy <= {lack2_sy[0], add_lack2};
            rreq_sy  <= {rreq_sy[0], add_rreq};
        end
    end

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(rr_ptr) + k) % N);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        moving = 1'b0;
        case (state)
            IDLE:     moving = found;
            ISSUE:    moving = lack1_s & lack2_s;
            IN_RTZ:   moving = ~lack1_s & ~lack2_s;
            OUT_WAIT: moving = rreq_s;
            OUT_RTZ:  moving = ~rreq_s;
            RESP:     moving = resp_ready[cur];
            default:  moving = 1'b1;
        endcase
    end

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;
    logic          busy;

    assign busy = (state == ISSUE) || (state == IN_RTZ) ||
                  (state == OUT_WAIT) || (state == OUT_RTZ);
    assign tmo  = busy && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!busy || moving || tmo)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur         <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            add_lreq1   <= 1'b0;
            add_lreq2   <= 1'b0;
            add_ldata1  <= '0;
            add_ldata2  <= '0;
            add_rack    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= '0;
            timeout_err <= tmo;
            if (tmo) begin
                // Abandon the adder transaction but still release the requester
                add_lreq1  <= 1'b0;
                add_lreq2  <= 1'b0;
                add_rack   <= 1'b0;
                resp_data  <= '0;
                resp_valid <= ONE << cur;
                state      <= RESP;
            end else if (moving) begin
                case (state)
                    IDLE: begin
                        cur        <= gnt_idx;
                        req_ready  <= ONE << gnt_idx;
                        add_ldata1 <= req_op1[gnt_idx*WIDTH +: WIDTH];
                        add_ldata2 <= req_op2[gnt_idx*WIDTH +: WIDTH];
                        add_lreq1  <= 1'b1;
                        add_lreq2  <= 1'b1;
                        state      <= ISSUE;
                    end
                    ISSUE: begin
                        add_lreq1 <= 1'b0;
                        add_lreq2 <= 1'b0;
                        state     <= IN_RTZ;
                    end
                    IN_RTZ: state <= OUT_WAIT;
                    OUT_WAIT: begin
                        resp_data <= add_rdata;
                        add_rack  <= 1'b1;
                        state     <= OUT_RTZ;
                    end
                    OUT_RTZ: begin
                        add_rack   <= 1'b0;
                        resp_valid <= ONE << cur;
                        state      <= RESP;
                    end
                    RESP: begin
                        resp_valid <= '0;
                        rr_ptr     <= nxt_ptr;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Clocked round-robin arbiter that shares one asynchronous 4-phase `adder` stage among N synchronous requesters.
- Accepts operand pairs on valid/ready ports.
- Drives the adder's two bundled-data input channels, collects the sum from its output channel, and returns the sum to the granted requester.
- Sits between the clocked PE/accumulator logic and the shared self-timed adder.

Parameters:
- WIDTH, 10, operand/result width; must match adder WIDTH.
- N, 4, number of requesters (2..8).
- TIMEOUT, 255, watchdog limit in clk cycles; used only with ADDER_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  requester i has an operand pair
- req_op1  in  N*WIDTH  operand 1, slice i = [i*WIDTH +: WIDTH]
- req_op2  in  N*WIDTH  operand 2, same slicing
- req_ready  out  N  one-hot, 1-cycle accept pulse
- resp_valid  out  N  one-hot, result valid for requester i
- resp_data  out  WIDTH  sum, shared by all requesters
- resp_ready  in  N  requester i consumes result
- add_lreq1, add_lreq2  out  1  adder input requests
- add_ldata1, add_ldata2  out  WIDTH  adder operands
- add_lack1, add_lack2  in  1  adder input acks (asynchronous)
- add_rreq  in  1  adder output request (asynchronous)
- add_rdata  in  WIDTH  adder sum (bundled with add_rreq)
- add_rack  out  1  adder output ack
- timeout_err  out  1  watchdog error pulse

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - add_ldata registers 0.
  - State IDLE; rr_ptr = 0; synchronizers cleared.
  - Reset mid-operation abandons the transaction: add_lreq*/add_rack drop to 0 immediately, and no response is issued.
- Synchronizers: add_lack1, add_lack2 and add_rreq each pass through a 2-flop synchronizer. All FSM decisions use the synchronized versions.
- Arbitration (IDLE):
  - Grant g = the lowest index ≥ rr_ptr with req_valid set, wrapping modulo N.
  - On grant: pulse req_ready[g] for one cycle, latch op1/op2 into add_ldata1/2, go to ISSUE.
  - add_ldata is held stable from latch until the next grant.
- FSM:
  - ISSUE: add_lreq1 = add_lreq2 = 1; wait until sync lack1 and sync lack2 are both 1 → IN_RTZ.
  - IN_RTZ: add_lreq1/2 = 0; wait until both sync lacks are 0 → OUT_WAIT.
  - OUT_WAIT: wait for sync rreq = 1. Then capture add_rdata into resp_data and set add_rack = 1 → OUT_RTZ. Data is sampled ≥2 cycles after raw add_rreq rose, which satisfies the bundling constraint.
  - OUT_RTZ: hold add_rack = 1 until sync rreq = 0, then add_rack = 0 → RESP.
  - RESP: resp_valid[g] = 1 with resp_data stable. On resp_ready[g] = 1, clear resp_valid in the same clock edge, set rr_ptr = (g+1) mod N → IDLE.
- Early output: add_rreq may rise before IN_RTZ completes. It stays high until add_rack, so OUT_WAIT sees it immediately. Data is captured in OUT_WAIT only.
- Timing: at most one transaction in flight. No new grant until RESP completes.
- Minimum latency from req_ready to resp_valid: 4 state transitions plus synchronizer delays (≥9 cycles with an instantaneous adder).
- Arithmetic: resp_data = (op1 + op2) mod 2^WIDTH, exactly as produced by the adder. No carry is reported.
- Simultaneous requests resolve in round-robin order.
- req_valid deasserted before its grant is simply not granted. No request is lost once req_ready has pulsed.
- With no requests, the FSM stays in IDLE and all handshake outputs stay at 0.

Optional Feature:
- Macro ADDER_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter runs in ISSUE, IN_RTZ, OUT_WAIT and OUT_RTZ, and resets on every state change.
  - Reaching TIMEOUT forces add_lreq1/2 = 0 and add_rack = 0.
  - It pulses timeout_err for 1 cycle and enters RESP with resp_data = 0, so the requester is still released.
  - rr_ptr advances normally.
- Undefined: no counter, and timeout_err is tied to 0.

Test Plan:
- Single request on port 0, 123+456 with an ideal 4-phase adder model (delay 6ns) → resp_valid[0] with resp_data = 579; add_lreq and add_rack return to 0.
- Wrap-around: 800+300 on port 1 → resp_data = 76 (1100 mod 1024).
- Round-robin: ports 0, 2, 3 valid simultaneously from reset, each with distinct operands → grant order 0, 2, 3, then port 0 again. Each resp_data matches its own operands.
- Back-pressure: hold resp_ready[1] low for 20 cycles → resp_valid[1] and resp_data stay stable, and no new req_ready pulses occur.
- Reset mid-op: assert rst_n = 0 while in OUT_RTZ → add_rack = 0 immediately, all outputs 0, and after release a new request 5+7 → 12.
- With ADDER_ARB_TIMEOUT_EN and TIMEOUT = 16, the adder model never acks → timeout_err pulses 16 cycles after ISSUE entry, resp_data = 0, and the FSM returns to IDLE.
